// File: rtl/write_stream_adapter.sv
// write_stream_adapter
//   Write-side front end of the async FIFO. Turns a valid/ready producer stream
//   into the write_enable/write_data strobe used by the TMR write handler. It never
//   strobes into a full FIFO. A 2-entry skid buffer means in_ready is derived from
//   local state and flush only, with no path from write_full.
//   The block also counts delivered words and cycles stalled by full.
// Ports
//   write_clock  : write-domain clock (rising edge)
//   reset        : asynchronous, active-low reset
//   flush        : synchronous discard of buffered words
//   in_valid     : producer word valid
//   in_data      : producer word
//   in_ready     : adapter can accept a word this cycle
//   write_full   : voted full flag from the write handler
//   write_enable : write strobe to the write handler
//   write_data   : head word, written when write_enable=1 (0 when empty)
//   buf_count    : words held (0..2), also the FSM state
//   write_count  : words delivered, wraps
//   stall_count  : cycles blocked by full, saturates
module write_stream_adapter #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   write_clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    input  logic                   write_full,
    output logic                   write_enable,
    output logic [DATA_WIDTH-1:0]  write_data,
    output logic [1:0]             buf_count,
    output logic [COUNT_WIDTH-1:0] write_count,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   head;
    logic [DATA_WIDTH-1:0]   head_next;
    logic [DATA_WIDTH-1:0]   tail;
    logic [DATA_WIDTH-1:0]   tail_next;
    logic                    accept;
    logic                    drain;
    logic                    stall_inc;

    // State and buffer registers
    always_ff @(posedge write_clock or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
        end
    end

    // Next-state, buffer movement and handshake outputs
    always_comb begin
        state_next   = state;
        head_next    = head;
        tail_next    = tail;
        in_ready     = (state != ST_TWO) && !flush;
        write_enable = (state != ST_EMPTY) && !write_full && !flush;
        accept       = in_valid && in_ready;
        drain        = write_enable;

        if (flush) begin
            state_next = ST_EMPTY;
            head_next  = '0;
            tail_next  = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next = ST_ONE;
                        head_next  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        // Old head leaves, new word takes its place.
                        head_next = in_data;
                    end else if (accept) begin
                        state_next = ST_TWO;
                        tail_next  = in_data;
                    end else if (drain) begin
                        state_next = ST_EMPTY;
                        head_next  = '0;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_next = ST_ONE;
                        head_next  = tail;
                        tail_next  = '0;
                    end
                end
                default: begin
                    // Illegal encoding: recover to empty.
                    state_next = ST_EMPTY;
                    head_next  = '0;
                    tail_next  = '0;
                end
            endcase
        end
    end

    // Head is kept cleared while empty, so it reads 0 then.
    assign write_data = head;
    assign buf_count  = 2'(state);
    assign stall_inc  = (state != ST_EMPTY) && write_full && !flush;

    // Statistics; neither counter is touched by flush
    always_ff @(posedge write_clock or negedge reset) begin
        if (!reset) begin
            write_count <= '0;
            stall_count <= '0;
        end else begin
            if (drain) begin
                write_count <= write_count + COUNT_WIDTH'(1);
            end
            if (stall_inc && (stall_count != {COUNT_WIDTH{1'b1}})) begin
                stall_count <= stall_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_write_stream_adapter.sv
// Bench for write_stream_adapter: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model. Two instances share the
// stimulus: default counter width and a 4-bit one for wrap/saturation.
module tb_write_stream_adapter;

    logic        write_clock = 1'b0;
    logic        reset       = 1'b0;
    logic        flush       = 1'b0;
    logic        in_valid    = 1'b0;
    logic [7:0]  in_data     = 8'h00;
    logic        write_full  = 1'b0;

    logic        in_ready_a, write_enable_a;
    logic [7:0]  write_data_a;
    logic [1:0]  buf_count_a;
    logic [15:0] write_count_a, stall_count_a;

    logic        in_ready_b, write_enable_b;
    logic [7:0]  write_data_b;
    logic [1:0]  buf_count_b;
    logic [3:0]  write_count_b, stall_count_b;

    int tests  = 0;
    int errors = 0;

    // Reference model: FIFO contents plus raw event totals since reset
    logic [7:0] q[$];
    int         total_writes = 0;
    int         total_stalls = 0;

    always #5 write_clock = ~write_clock;

    write_stream_adapter #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut_a (
        .write_clock (write_clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready_a),
        .write_full  (write_full),
        .write_enable(write_enable_a),
        .write_data  (write_data_a),
        .buf_count   (buf_count_a),
        .write_count (write_count_a),
        .stall_count (stall_count_a)
    );

    write_stream_adapter #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut_b (
        .write_clock (write_clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready_b),
        .write_full  (write_full),
        .write_enable(write_enable_b),
        .write_data  (write_data_b),
        .buf_count   (buf_count_b),
        .write_count (write_count_b),
        .stall_count (stall_count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model
    task automatic check_all(input string tag);
        logic       exp_ready, exp_we;
        logic [7:0] exp_data;
        int         n;
        n         = q.size();
        exp_ready = (n < 2) && !flush;
        exp_we    = (n > 0) && !write_full && !flush;
        exp_data  = (n > 0) ? q[0] : 8'h00;
        check({tag, ".in_ready"},     32'(in_ready_a),     32'(exp_ready));
        check({tag, ".write_enable"}, 32'(write_enable_a), 32'(exp_we));
        check({tag, ".write_data"},   32'(write_data_a),   32'(exp_data));
        check({tag, ".buf_count"},    32'(buf_count_a),    32'(n));
        check({tag, ".write_count"},  32'(write_count_a),  32'(total_writes % 65536));
        check({tag, ".stall_count"},  32'(stall_count_a),  32'((total_stalls > 65535) ? 65535 : total_stalls));
        check({tag, ".b_we"},         32'(write_enable_b), 32'(exp_we));
        check({tag, ".b_data"},       32'(write_data_b),   32'(exp_data));
        check({tag, ".b_write_count"}, 32'(write_count_b), 32'(total_writes % 16));
        check({tag, ".b_stall_count"}, 32'(stall_count_b), 32'((total_stalls > 15) ? 15 : total_stalls));
    endtask

    // One clock cycle: drive after the falling edge, check, then advance the model
    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic full, input logic fl);
        logic acc, drn;
        int   n;
        in_valid   = v;
        in_data    = d;
        write_full = full;
        flush      = fl;
        #1;
        check_all(tag);
        n   = q.size();
        acc = v && (n < 2) && !fl;
        drn = (n > 0) && !full && !fl;
        @(posedge write_clock);
        if (fl) begin
            q.delete();
        end else begin
            if (n > 0 && full) total_stalls++;
            if (drn) begin
                void'(q.pop_front());
                total_writes++;
            end
            if (acc) q.push_back(d);
        end
        @(negedge write_clock);
    endtask

    task automatic model_reset();
        q.delete();
        total_writes = 0;
        total_stalls = 0;
    endtask

    initial begin
        // Reset state
        model_reset();
        #12;
        check_all("reset");
        @(negedge write_clock);
        reset = 1'b1;
        @(negedge write_clock);

        // Stream 0x01..0x10 with no backpressure, then let it drain
        for (int i = 1; i <= 16; i++) step("stream", 1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("stream_tail", 1'b0, 8'h00, 1'b0, 1'b0);
        check("stream.count16", 32'(write_count_a), 32'd16);

        // Full stall: one word held, full for 5 cycles, producer keeps offering
        step("stall_fill", 1'b1, 8'h11, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("stall", 1'b1, 8'h22 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("stall_release", 1'b0, 8'h00, 1'b0, 1'b0);

        // Simultaneous accept and drain in ONE
        step("simul_a", 1'b1, 8'h3C, 1'b0, 1'b0);
        step("simul_b", 1'b1, 8'hA5, 1'b0, 1'b0);
        step("simul_c", 1'b0, 8'h00, 1'b0, 1'b0);
        step("simul_d", 1'b0, 8'h00, 1'b0, 1'b0);

        // Flush with two words held
        step("flush_a", 1'b1, 8'h55, 1'b1, 1'b0);
        step("flush_b", 1'b1, 8'h66, 1'b1, 1'b0);
        step("flush",   1'b1, 8'h77, 1'b1, 1'b1);
        step("flush_after", 1'b0, 8'h00, 1'b0, 1'b0);

        // Long full stretch to saturate the narrow stall counter
        step("sat_fill", 1'b1, 8'h99, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step("sat", 1'b0, 8'h00, 1'b1, 1'b0);
        check("sat.stall4", 32'(stall_count_b), 32'd15);

        // Randomized traffic with varying backpressure and occasional flush
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 250; i++) begin
                step("rand",
                     ($urandom_range(99) < 75) ? 1'b1 : 1'b0,
                     8'($urandom),
                     ($urandom_range(99) < 20 * phase) ? 1'b1 : 1'b0,
                     ($urandom_range(99) < 4) ? 1'b1 : 1'b0);
            end
        end

        // Asynchronous reset mid-traffic, observed without a clock edge
        in_valid = 1'b1;
        write_full = 1'b1;
        flush = 1'b0;
        step("pre_reset", 1'b1, 8'hE1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge write_clock);
        reset = 1'b1;

        // Traffic after reset, covering wrap of the narrow write counter
        for (int i = 0; i < 40; i++) step("post_reset", 1'b1, 8'($urandom), 1'b0, 1'b0);
        check("post.count_a", 32'(write_count_a), 32'(total_writes));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
